evolved_cut_sequencer: RTL

Test sequencer for small evolved LCELL circuits-under-test (CUT) with a few inputs and one output. On start, it drives every input vector in ascending order. After each vector it waits a settle window, then samples the CUT output over several cycles to classify it as stable-0, stable-1 or oscillating. It compares the stable results to an expected truth table and reports pass/fail plus per-vector result masks for the host/JTAG readout logic.

---
 rtl/evolved_cut_sequencer_if.sv | 38 +++
 rtl/evolved_cut_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/evolved_cut_sequencer_if.sv
// Host-side control and readout bundle of the evolved CUT sequencer.
// The host (or JTAG readout logic) is the master; the sequencer is the slave.
interface evolved_cut_sequencer_if #(
  parameter int IN_WIDTH = 2
) ();
  localparam int NV = 2 ** IN_WIDTH;

  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  logic          pass;
  logic [NV-1:0] result;
  logic [NV-1:0] osc_mask;
  logic [NV-1:0] fail_mask;

  modport master (
    output start,
    output abort,
    input  busy,
    input  done,
    input  pass,
    input  result,
    input  osc_mask,
    input  fail_mask
  );

  modport slave (
    input  start,
    input  abort,
    output busy,
    output done,
    output pass,
    output result,
    output osc_mask,
    output fail_mask
  );
endinterface

// File: rtl/evolved_cut_sequencer.sv
// Test sequencer for small evolved LCELL circuits-under-test.
// Steps cut_in through every vector in ascending order, lets the CUT settle,
// samples its synchronized output to classify stable-0 / stable-1 / oscillating,
// and compares stable results against an expected truth table.
module evolved_cut_sequencer #(
  parameter int                     IN_WIDTH      = 2,
  parameter int                     SETTLE_CYCLES = 16,
  parameter int                     SAMPLE_COUNT  = 8,
  parameter logic [2**IN_WIDTH-1:0] EXPECTED      = 4'b1000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  evolved_cut_sequencer_if.slave    hostIf,
  output logic [IN_WIDTH-1:0]       cut_in_o,
  input  logic                      cut_out_i
);

  localparam int NV      = 2 ** IN_WIDTH;
  localparam int MAX_CNT = (SETTLE_CYCLES > SAMPLE_COUNT) ? SETTLE_CYCLES : SAMPLE_COUNT;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    SAMPLE_LAST = CNT_W'(SAMPLE_COUNT - 1);
  localparam logic [IN_WIDTH-1:0] VEC_LAST    = IN_WIDTH'(NV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    RECORD,
    DONE
  } state_t;

  state_t              state_q;
  logic [IN_WIDTH-1:0] vec_q;
  logic [IN_WIDTH-1:0] cutIn_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                syncMeta_q;
  logic                syncOut_q;
  logic                refSample_q;
  logic                oscFlag_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [NV-1:0]       result_q;
  logic [NV-1:0]       oscMask_q;
  logic [NV-1:0]       failMask_q;

  logic                recFail;
  logic [NV-1:0]       failMask_d;

  // Two-flop synchronizer: the CUT output is asynchronous to clk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      syncMeta_q <= 1'b0;
      syncOut_q  <= 1'b0;
    end else begin
      syncMeta_q <= cut_out_i;
      syncOut_q  <= syncMeta_q;
    end
  end

  // Fail mask as it will look after the current vector is recorded, so pass can include it.
  always_comb begin
    recFail             = oscFlag_q | (refSample_q != EXPECTED[vec_q]);
    failMask_d          = failMask_q;
    failMask_d[vec_q]   = recFail;
  end

  // Main sequencing FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      cutIn_q     <= '0;
      cnt_q       <= '0;
      refSample_q <= 1'b0;
      oscFlag_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      result_q    <= '0;
      oscMask_q   <= '0;
      failMask_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (hostIf.abort && (state_q == SETTLE || state_q == SAMPLE || state_q == RECORD)) begin
        state_q   <= IDLE;
        busy_q    <= 1'b0;
        cutIn_q   <= '0;
        pass_q    <= 1'b0;
        cnt_q     <= '0;
        vec_q     <= '0;
        oscFlag_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (hostIf.start) begin
              result_q   <= '0;
              oscMask_q  <= '0;
              failMask_q <= '0;
              pass_q     <= 1'b0;
              cutIn_q    <= '0;
              vec_q      <= '0;
              cnt_q      <= '0;
              oscFlag_q  <= 1'b0;
              busy_q     <= 1'b1;
              state_q    <= SETTLE;
            end
          end

          SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
              cnt_q   <= '0;
              state_q <= SAMPLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end

          SAMPLE: begin
            if (cnt_q == '0) begin
              refSample_q <= syncOut_q;
            end else if (syncOut_q != refSample_q) begin
              oscFlag_q <= 1'b1;
            end
            if (cnt_q == SAMPLE_LAST) begin
              cnt_q   <= '0;
              state_q <= RECORD;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end

          RECORD: begin
            result_q[vec_q]  <= refSample_q;
            oscMask_q[vec_q] <= oscFlag_q;
            failMask_q       <= failMask_d;
            oscFlag_q        <= 1'b0;
            if (vec_q == VEC_LAST) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              pass_q  <= (failMask_d == '0);
            end else begin
              vec_q   <= vec_q + 1'b1;
              cutIn_q <= vec_q + 1'b1;
              cnt_q   <= '0;
              state_q <= SETTLE;
            end
          end

          DONE: begin
            state_q <= IDLE;
          end

          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign cut_in_o         = cutIn_q;
  assign hostIf.busy      = busy_q;
  assign hostIf.done      = done_q;
  assign hostIf.pass      = pass_q;
  assign hostIf.result    = result_q;
  assign hostIf.osc_mask  = oscMask_q;
  assign hostIf.fail_mask = failMask_q;

endmodule
